gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Parametrised, self-contained GCD unit: FSM plus datapath in one block.
- Operands enter through a valid/ready handshake; the result leaves through a valid/ready handshake.
- Two algorithms, selected per operation: subtractive (Euclid) and binary (Stein).
- Reports the iteration count and a both-zero flag. Successor to the fixed 8-bit, externally-sequenced GCD datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNTW, WIDTH, width of the iteration counter; counter saturates at all-ones.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept operands.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- mode_in  in  1  0 = subtractive, 1 = binary; sampled on accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- gcd_out  out  WIDTH  gcd(A,B).
- iter_out  out  CNTW  CALC cycles spent on this operation.
- zero_out  out  1  both operands were zero (gcd_out = 0).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, immediate): state IDLE; in_ready=1, out_valid=0, gcd_out=0, iter_out=0, zero_out=0, busy=0. All internal regs cleared. An operation in flight is dropped silently.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A, B and mode; clear k (shift count) and iteration counter; go to CALC next cycle.
- CALC (in_ready=0): each cycle, increment the counter (saturating), then evaluate one rule in priority order:
  1. A==0 or B==0: result = A|B; zero_out = (A==0 && B==0); go to DONE.
  2. A==B: result = A (subtractive) or A<<k (binary, truncated to WIDTH); go to DONE.
  3. Subtractive: if A>B then A<=A-B, else B<=B-A.
  4. Binary:
     - both even: A>>=1, B>>=1, k++.
     - else A even: A>>=1.
     - else B even: B>>=1.
     - else A>B: A<=(A-B)>>1.
     - else: B<=(B-A)>>1.
- k width: clog2(WIDTH)+1. All subtractions are unsigned, and each rule never underflows.
- DONE:
  - out_valid=1; gcd_out, iter_out and zero_out are stable.
  - Outputs are held unchanged while out_ready=0 (no timeout).
  - On out_ready: go to IDLE next cycle; out_valid drops.
  - gcd_out and iter_out keep their last values in IDLE. Only out_valid qualifies them.
- Latency: accept edge, then N CALC cycles (N = iter_out), then DONE. Minimum operation is 1 CALC cycle (a zero or equal operand).
- Throughput: one operation in flight. in_ready is low from accept until the DONE->IDLE transition.
- mode_in, a_in and b_in changes outside the accept cycle have no effect.
- Worst case, subtractive (255,1) at WIDTH=8: 255 CALC cycles. Binary is bounded by about 2*WIDTH.

Decomposition:
- Package gcd_pkg holds:
  - state enum {IDLE, CALC, DONE}.
  - mode constants MODE_SUB=0, MODE_BIN=1.
  - a clog2 helper function.
- Sub-module gcd_step (combinational, parametrised WIDTH). It takes A, B, k and mode and returns next A, B, k, plus a done flag and the result. The engine instantiates it once and registers its outputs.

Test Plan:
- Subtractive, mode=0, (12,8) -> gcd_out=4, iter_out=3, zero_out=0.
- Binary, mode=1, (12,8) -> gcd_out=4, iter_out=5.
- Zero cases:
  - (0,9) -> gcd_out=9, iter_out=1, zero_out=0.
  - (0,0) -> gcd_out=0, zero_out=1.
- Worst case, subtractive (255,1) -> gcd_out=1, iter_out=255. Binary (255,1) -> gcd_out=1, iter_out <= 16.
- Backpressure: out_ready held low for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. in_valid pulses during CALC/DONE are ignored. The next pair (48,18) is accepted only after out_ready, giving gcd_out=6.
- Reset mid-CALC: assert rst during (200,3) -> out_valid=0, in_ready=1 immediately (asynchronous, same cycle). Then (7,7) -> gcd_out=7, iter_out=1.

Source files
------------

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types, mode encodings and helpers for the GCD engine
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// rtl/gcd_step.sv - one combinational GCD iteration (subtractive or binary)
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    input  logic             mode,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [KW-1:0]    k_nxt,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        a_nxt  = a;
        b_nxt  = b;
        k_nxt  = k;
        done   = 1'b0;
        result = '0;
        zero   = 1'b0;
        if (a == '0 || b == '0) begin
            done   = 1'b1;
            result = a | b;
            zero   = (a == '0) && (b == '0);
        end else if (a == b) begin
            done   = 1'b1;
            // binary mode removed k common factors of two; restore them here
            result = (mode == MODE_BIN) ? (a << k) : a;
        end else if (mode == MODE_SUB) begin
            if (a > b) a_nxt = a - b;
            else       b_nxt = b - a;
        end else begin
            if (!a[0] && !b[0]) begin
                a_nxt = a >> 1;
                b_nxt = b >> 1;
                k_nxt = k + KW'(1);
            end else if (!a[0]) begin
                a_nxt = a >> 1;
            end else if (!b[0]) begin
                b_nxt = b >> 1;
            end else if (a > b) begin
                a_nxt = (a - b) >> 1;
            end else begin
                b_nxt = (b - a) >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - handshaked iterative GCD unit with selectable algorithm
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNTW-1:0]  iter_out,
    output logic             zero_out,
    output logic             busy
);

    localparam int KW = clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [KW-1:0]    k_r;
    logic             mode_r;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_next;

    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic [KW-1:0]    k_nxt;
    logic             step_done;
    logic [WIDTH-1:0] step_result;
    logic             step_zero;

    gcd_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .a      (a_r),
        .b      (b_r),
        .k      (k_r),
        .mode   (mode_r),
        .a_nxt  (a_nxt),
        .b_nxt  (b_nxt),
        .k_nxt  (k_nxt),
        .done   (step_done),
        .result (step_result),
        .zero   (step_zero)
    );

    assign cnt_next  = (&cnt) ? cnt : cnt + CNTW'(1);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            k_r      <= '0;
            mode_r   <= MODE_SUB;
            cnt      <= '0;
            gcd_out  <= '0;
            iter_out <= '0;
            zero_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a_in;
                        b_r    <= b_in;
                        mode_r <= mode_in;
                        k_r    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt_next;
                    if (step_done) begin
                        gcd_out  <= step_result;
                        iter_out <= cnt_next;
                        zero_out <= step_zero;
                        state    <= DONE;
                    end else begin
                        a_r <= a_nxt;
                        b_r <= b_nxt;
                        k_r <= k_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - directed self-checking bench for gcd_engine
module tb_gcd_engine;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       mode_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] gcd_out;
    logic [7:0] iter_out;
    logic       zero_out;
    logic       busy;

    int n_checks;
    int n_fail;

    gcd_engine #(.WIDTH(8), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .mode_in   (mode_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gcd_out   (gcd_out),
        .iter_out  (iter_out),
        .zero_out  (zero_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic m);
        a_in     = a;
        b_in     = b;
        mode_in  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = 8'hxx;
        b_in     = 8'hxx;
    endtask

    task automatic wait_done(output int cycles, output bit timed_out);
        cycles = 0;
        while (!out_valid && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        timed_out = !out_valid;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (gcd_out !== 8'd0) begin n_fail++; $display("FAIL reset_gcd got %0d want 0", gcd_out); end
        n_checks++; if (iter_out !== 8'd0) begin n_fail++; $display("FAIL reset_iter got %0d want 0", iter_out); end
        n_checks++; if (zero_out !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", zero_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_subtractive();
        int cyc; bit to;
        accept(8'd12, 8'd8, 1'b0);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL sub_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); end
        wait_done(cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL sub_timeout got no out_valid want out_valid"); end
        n_checks++; if (gcd_out !== 8'd4) begin n_fail++; $display("FAIL sub_12_8_gcd got %0d want 4", gcd_out); end
        n_checks++; if (iter_out !== 8'd3) begin n_fail++; $display("FAIL sub_12_8_iter got %0d want 3", iter_out); end
        n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL sub_12_8_latency got %0d want 3", cyc); end
        n_checks++; if (zero_out !== 1'b0) begin n_fail++; $display("FAIL sub_12_8_zero got %b want 0", zero_out); end
        consume();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL sub_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        n_checks++; if (gcd_out !== 8'd4 || iter_out !== 8'd3) begin n_fail++; $display("FAIL sub_idle_hold got %0d/%0d want 4/3", gcd_out, iter_out); end
    endtask

    task automatic test_binary();
        int cyc; bit to;
        accept(8'd12, 8'd8, 1'b1);
        wait_done(cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bin_timeout got no out_valid want out_valid"); end
        n_checks++; if (gcd_out !== 8'd4) begin n_fail++; $display("FAIL bin_12_8_gcd got %0d want 4", gcd_out); end
        n_checks++; if (iter_out !== 8'd5) begin n_fail++; $display("FAIL bin_12_8_iter got %0d want 5", iter_out); end
        consume();
        accept(8'd255, 8'd1, 1'b1);
        wait_done(cyc, to);
        n_checks++; if (gcd_out !== 8'd1) begin n_fail++; $display("FAIL bin_255_1_gcd got %0d want 1", gcd_out); end
        n_checks++; if (iter_out !== 8'd8) begin n_fail++; $display("FAIL bin_255_1_iter got %0d want 8", iter_out); end
        consume();
        accept(8'd40, 8'd24, 1'b1);
        wait_done(cyc, to);
        n_checks++; if (gcd_out !== 8'd8) begin n_fail++; $display("FAIL bin_40_24_gcd got %0d want 8", gcd_out); end
        consume();
    endtask

    task automatic test_zero();
        int cyc; bit to;
        accept(8'd0, 8'd9, 1'b0);
        wait_done(cyc, to);
        n_checks++; if (gcd_out !== 8'd9) begin n_fail++; $display("FAIL zero_0_9_gcd got %0d want 9", gcd_out); end
        n_checks++; if (iter_out !== 8'd1) begin n_fail++; $display("FAIL zero_0_9_iter got %0d want 1", iter_out); end
        n_checks++; if (zero_out !== 1'b0) begin n_fail++; $display("FAIL zero_0_9_flag got %b want 0", zero_out); end
        consume();
        accept(8'd0, 8'd0, 1'b1);
        wait_done(cyc, to);
        n_checks++; if (gcd_out !== 8'd0) begin n_fail++; $display("FAIL zero_0_0_gcd got %0d want 0", gcd_out); end
        n_checks++; if (zero_out !== 1'b1) begin n_fail++; $display("FAIL zero_0_0_flag got %b want 1", zero_out); end
        n_checks++; if (iter_out !== 8'd1) begin n_fail++; $display("FAIL zero_0_0_iter got %0d want 1", iter_out); end
        consume();
        accept(8'd5, 8'd0, 1'b1);
        wait_done(cyc, to);
        n_checks++; if (gcd_out !== 8'd5 || zero_out !== 1'b0) begin n_fail++; $display("FAIL zero_5_0 got %0d/%b want 5/0", gcd_out, zero_out); end
        consume();
    endtask

    task automatic test_worst_case();
        int cyc; bit to;
        accept(8'd255, 8'd1, 1'b0);
        wait_done(cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL worst_timeout got no out_valid want out_valid"); end
        n_checks++; if (gcd_out !== 8'd1) begin n_fail++; $display("FAIL worst_gcd got %0d want 1", gcd_out); end
        n_checks++; if (iter_out !== 8'd255) begin n_fail++; $display("FAIL worst_iter got %0d want 255", iter_out); end
        n_checks++; if (cyc != 255) begin n_fail++; $display("FAIL worst_latency got %0d want 255", cyc); end
        consume();
    endtask

    task automatic test_back_to_back();
        int cyc; bit to;
        accept(8'd100, 8'd75, 1'b0);
        // a competing pair sits on the input for the whole operation
        a_in = 8'd48; b_in = 8'd18; mode_in = 1'b0; in_valid = 1'b1;
        wait_done(cyc, to);
        n_checks++; if (gcd_out !== 8'd25 || iter_out !== 8'd4) begin n_fail++; $display("FAIL bp_first got %0d/%0d want 25/4", gcd_out, iter_out); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || gcd_out !== 8'd25 || iter_out !== 8'd4 || zero_out !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got v=%b r=%b g=%0d i=%0d want 1/0/25/4", i, out_valid, in_ready, gcd_out, iter_out);
            end
        end
        in_valid = 1'b1;
        consume();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept got busy=%b want 1", busy); end
        wait_done(cyc, to);
        n_checks++; if (gcd_out !== 8'd6) begin n_fail++; $display("FAIL bp_48_18_gcd got %0d want 6", gcd_out); end
        n_checks++; if (iter_out !== 8'd5) begin n_fail++; $display("FAIL bp_48_18_iter got %0d want 5", iter_out); end
        consume();
    endtask

    task automatic test_reset_mid_calc();
        int cyc; bit to;
        accept(8'd200, 8'd3, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async got v=%b r=%b b=%b want 0/1/0", out_valid, in_ready, busy); end
        n_checks++; if (gcd_out !== 8'd0 || iter_out !== 8'd0) begin n_fail++; $display("FAIL rmid_clear got %0d/%0d want 0/0", gcd_out, iter_out); end
        @(negedge clk);
        rst = 1'b0;
        accept(8'd7, 8'd7, 1'b0);
        wait_done(cyc, to);
        n_checks++; if (gcd_out !== 8'd7) begin n_fail++; $display("FAIL rmid_7_7_gcd got %0d want 7", gcd_out); end
        n_checks++; if (iter_out !== 8'd1) begin n_fail++; $display("FAIL rmid_7_7_iter got %0d want 1", iter_out); end
        consume();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 8'd0;
        b_in      = 8'd0;
        mode_in   = 1'b0;
        test_reset();
        test_subtractive();
        test_binary();
        test_zero();
        test_worst_case();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
